// File: rtl/uart_bus_dump.sv
// Reads WORD_COUNT bus words from BASE_ADDR upward and streams them out of tx_pin as 8N1 UART frames.
// Define UART_DUMP_HEX_EN to send each word as eight ASCII hex characters followed by CR LF instead of four raw bytes.
module uart_bus_dump #(
  parameter int unsigned  CLKS_PER_BIT = 5625,
  parameter int unsigned  WORD_COUNT   = 4,
  parameter logic [13:0]  BASE_ADDR    = 14'h0041
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        bus_req,
  output logic        bus_use,
  input  logic        bus_available,
  input  logic        fulfilled,
  output logic [13:0] bus_address,
  output logic [7:0]  bus_control,
  input  logic [31:0] bus_datao,
  output logic        tx_pin
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] USE  = 3'd2;
  localparam logic [2:0] SEND = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  IDX_LAST  = 8'(WORD_COUNT - 1);
  localparam logic [3:0]  STOP_BIT  = 4'd9;
`ifdef UART_DUMP_HEX_EN
  localparam logic [3:0]  LAST_FRAME = 4'd9;
`else
  localparam logic [3:0]  LAST_FRAME = 4'd3;
`endif

  logic [2:0]  state_r;
  logic [31:0] word_r;
  logic [15:0] baud_r;
  logic [3:0]  bit_r;
  logic [3:0]  frame_r;
  logic [7:0]  idx_r;
  logic [13:0] addr_r;
  logic        busy_r, done_r, req_r, use_r, tx_r;
  logic [7:0]  frame_byte_s;
  logic        next_bit_s;

`ifdef UART_DUMP_HEX_EN
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) hex_char = 8'h30 + {4'h0, nib};
    else             hex_char = 8'h37 + {4'h0, nib};
  endfunction
`endif

  // Bit position 0 is the start bit, 1..8 the data LSB first, 9 the stop bit.
  function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] pos);
    logic [3:0] k;
    k = pos - 4'd1;
    if (pos == 4'd0)          frame_bit = 1'b0;
    else if (pos >= STOP_BIT) frame_bit = 1'b1;
    else                      frame_bit = data[k[2:0]];
  endfunction

  // Character carried by the frame currently on the line.
  always_comb begin
    frame_byte_s = 8'h00;
`ifdef UART_DUMP_HEX_EN
    case (frame_r)
      4'd0:    frame_byte_s = hex_char(word_r[31:28]);
      4'd1:    frame_byte_s = hex_char(word_r[27:24]);
      4'd2:    frame_byte_s = hex_char(word_r[23:20]);
      4'd3:    frame_byte_s = hex_char(word_r[19:16]);
      4'd4:    frame_byte_s = hex_char(word_r[15:12]);
      4'd5:    frame_byte_s = hex_char(word_r[11:8]);
      4'd6:    frame_byte_s = hex_char(word_r[7:4]);
      4'd7:    frame_byte_s = hex_char(word_r[3:0]);
      4'd8:    frame_byte_s = 8'h0D;
      4'd9:    frame_byte_s = 8'h0A;
      default: frame_byte_s = 8'h00;
    endcase
`else
    case (frame_r)
      4'd0:    frame_byte_s = word_r[31:24];
      4'd1:    frame_byte_s = word_r[23:16];
      4'd2:    frame_byte_s = word_r[15:8];
      4'd3:    frame_byte_s = word_r[7:0];
      default: frame_byte_s = 8'h00;
    endcase
`endif
    next_bit_s = frame_bit(frame_byte_s, bit_r + 4'd1);
  end

  // Dump sequencer; tx_pin is loaded one bit ahead so the line changes exactly on bit boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      word_r  <= 32'h0000_0000;
      baud_r  <= 16'd0;
      bit_r   <= 4'd0;
      frame_r <= 4'd0;
      idx_r   <= 8'd0;
      addr_r  <= BASE_ADDR;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      req_r   <= 1'b0;
      use_r   <= 1'b0;
      tx_r    <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= REQ;
            idx_r   <= 8'd0;
            addr_r  <= BASE_ADDR;
            busy_r  <= 1'b1;
            req_r   <= 1'b1;
          end
        end
        REQ: begin
          if (bus_available) begin
            state_r <= USE;
            req_r   <= 1'b0;
            use_r   <= 1'b1;
          end
        end
        USE: begin
          if (fulfilled) begin
            state_r <= SEND;
            word_r  <= bus_datao;
            use_r   <= 1'b0;
            baud_r  <= 16'd0;
            bit_r   <= 4'd0;
            frame_r <= 4'd0;
            tx_r    <= 1'b0;
          end
        end
        SEND: begin
          if (baud_r != BAUD_LAST) begin
            baud_r <= baud_r + 16'd1;
          end else begin
            baud_r <= 16'd0;
            if (bit_r != STOP_BIT) begin
              bit_r <= bit_r + 4'd1;
              tx_r  <= next_bit_s;
            end else if (frame_r != LAST_FRAME) begin
              frame_r <= frame_r + 4'd1;
              bit_r   <= 4'd0;
              tx_r    <= 1'b0;
            end else begin
              frame_r <= 4'd0;
              bit_r   <= 4'd0;
              tx_r    <= 1'b1;
              if (idx_r == IDX_LAST) begin
                state_r <= DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= REQ;
                idx_r   <= idx_r + 8'd1;
                addr_r  <= addr_r + 14'd1;
                req_r   <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          req_r   <= 1'b0;
          use_r   <= 1'b0;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign bus_req     = req_r;
  assign bus_use     = use_r;
  assign bus_address = addr_r;
  assign bus_control = 8'h00;
  assign tx_pin      = tx_r;

endmodule

// File: tb/tb_uart_bus_dump.sv
// Bench for uart_bus_dump: cycle model built from handshake rules plus a precomputed UART bit stream, and a line decoder.
// Follows the UART_DUMP_HEX_EN build of the design.
module tb_uart_bus_dump;
  localparam int          CPB  = 4;
  localparam int          WC   = 2;
  localparam logic [13:0] BASE = 14'h3FFF;
`ifdef UART_DUMP_HEX_EN
  localparam int NF = 10;
  localparam logic [31:0] W0 = 32'h00C0FFEE;
`else
  localparam int NF = 4;
  localparam logic [31:0] W0 = 32'hA55A0F01;
`endif
  localparam logic [31:0] W1 = 32'h12345678;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bus_available = 1'b0, fulfilled = 1'b0;
  logic busy, done, bus_req, bus_use, tx_pin;
  logic [13:0] bus_address;
  logic [7:0]  bus_control;
  logic [31:0] bus_datao = 32'h0;

  int checks = 0, errors = 0, n_done = 0;

  uart_bus_dump #(.CLKS_PER_BIT(CPB), .WORD_COUNT(WC), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .bus_req(bus_req), .bus_use(bus_use), .bus_available(bus_available),
    .fulfilled(fulfilled), .bus_address(bus_address), .bus_control(bus_control),
    .bus_datao(bus_datao), .tx_pin(tx_pin));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for grant, 2 owning bus, 3 sending, 4 done pulse.
  int   m_phase = 0, m_idx = 0;
  logic m_tx = 1'b1;
  logic m_q[$];
  string hexdig = "0123456789ABCDEF";

  function automatic logic [7:0] char_of(input logic [31:0] w, input int k);
`ifdef UART_DUMP_HEX_EN
    if (k == 8) return 8'h0D;
    if (k == 9) return 8'h0A;
    return hexdig[(w >> (28 - 4 * k)) & 32'hF];
`else
    return 8'((w >> (24 - 8 * k)) & 32'hFF);
`endif
  endfunction

  function automatic void build_stream(input logic [31:0] w);
    logic [7:0] c;
    for (int k = 0; k < NF; k++) begin
      c = char_of(w, k);
      repeat (CPB) m_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (CPB) m_q.push_back(c[b]);
      repeat (CPB) m_q.push_back(1'b1);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_idx = 0; m_tx = 1'b1; m_q.delete();
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_idx = 0; end
        1: if (bus_available) m_phase = 2;
        2: if (fulfilled) begin build_stream(bus_datao); m_tx = m_q.pop_front(); m_phase = 3; end
        3: if (m_q.size() > 0) m_tx = m_q.pop_front();
           else begin
             m_tx = 1'b1;
             if (m_idx == WC - 1) m_phase = 4;
             else begin m_idx++; m_phase = 1; end
           end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #2;
    chk("busy", busy, (m_phase != 0));
    chk("done", done, (m_phase == 4));
    chk("bus_req", bus_req, (m_phase == 1));
    chk("bus_use", bus_use, (m_phase == 2));
    chk("tx_pin", tx_pin, m_tx);
    chk("bus_control", bus_control, 8'h00);
    if (m_phase == 1 || m_phase == 2)
      chk("bus_address", bus_address, 32'((BASE + m_idx) % 16384));
    if (done) n_done++;
  end

  // UART line decoder sampling mid-bit.
  logic [7:0] dec_q[$];
  always begin
    logic [7:0] c;
    @(posedge clk); #2;
    if (rst_n && tx_pin == 1'b0) begin
      repeat (CPB / 2) begin @(posedge clk); #2; end
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) begin @(posedge clk); #2; end
        c[b] = tx_pin;
      end
      repeat (CPB) begin @(posedge clk); #2; end
      dec_q.push_back(c);
    end
  end

  function automatic logic sig_val(input int which);
    case (which)
      0: return bus_req;
      1: return bus_use;
      2: return done;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int max, input string name);
    int n = 0;
    while (sig_val(which) !== 1'b1 && n < max) begin @(negedge clk); n++; end
    chk(name, sig_val(which), 1'b1);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic serve_word(input logic [31:0] data, input logic [13:0] exp_addr,
                            input int avail_delay, input bit drop, input bit stray);
    wait_sig(0, 1000, "wait_bus_req");
    chk("addr_literal", bus_address, exp_addr);
    if (stray) begin
      bus_datao = 32'hDEADBEEF; fulfilled = 1'b1;
      @(negedge clk); fulfilled = 1'b0;
    end
    repeat (avail_delay) @(negedge clk);
    bus_available = 1'b1;
    wait_sig(1, 20, "wait_bus_use");
    if (drop) bus_available = 1'b0;
    repeat (3) @(negedge clk);
    bus_datao = data; fulfilled = 1'b1;
    @(negedge clk);
    fulfilled = 1'b0; bus_available = 1'b0; bus_datao = 32'h0;
  endtask

  task automatic check_bytes();
    logic [7:0] exp[$];
`ifdef UART_DUMP_HEX_EN
    exp = '{8'h30, 8'h30, 8'h43, 8'h30, 8'h46, 8'h46, 8'h45, 8'h45, 8'h0D, 8'h0A,
            8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};
`else
    exp = '{8'hA5, 8'h5A, 8'h0F, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
`endif
    repeat (10) @(negedge clk);
    chk("byte_count", dec_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dec_q.size(); i++)
      chk($sformatf("byte%0d", i), dec_q[i], exp[i]);
    dec_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_pin, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", bus_address, BASE);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // Full dump; second word sees a stray fulfilled in REQ and a grant dropped in USE.
    pulse_start();
    serve_word(W0, 14'h3FFF, 3, 1'b0, 1'b0);
    serve_word(W1, 14'h0000, 1, 1'b1, 1'b1);
    wait_sig(2, 1000, "wait_done1");
    wait_sig(3, 10, "wait_idle1");
    check_bytes();
    chk("done_count1", n_done, 1);

    // Grant withheld 50 cycles; start pulses in REQ, SEND and DONE are ignored.
    pulse_start();
    wait_sig(0, 10, "wait_bus_req2");
    repeat (50) @(negedge clk);
    chk("hold_req", bus_req, 1'b1);
    chk("hold_use", bus_use, 1'b0);
    chk("hold_tx", tx_pin, 1'b1);
    pulse_start();
    serve_word(W0, 14'h3FFF, 0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    pulse_start();
    serve_word(W1, 14'h0000, 2, 1'b0, 1'b0);
    wait_sig(2, 1000, "wait_done2");
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_restart", busy, 1'b0);
    chk("done_count2", n_done, 2);
    check_bytes();

    // Reset in the middle of the second frame.
    pulse_start();
    serve_word(W0, 14'h3FFF, 1, 1'b0, 1'b0);
    repeat (55) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", tx_pin, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_req", bus_req, 1'b0);
    chk("arst_use", bus_use, 1'b0);
    chk("arst_addr", bus_address, BASE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_rst_idle", busy, 1'b0);
    dec_q.delete();
    pulse_start();
    serve_word(W0, 14'h3FFF, 2, 1'b0, 1'b0);
    serve_word(W1, 14'h0000, 2, 1'b0, 1'b0);
    wait_sig(2, 1000, "wait_done3");
    wait_sig(3, 10, "wait_idle3");
    check_bytes();
    chk("done_count3", n_done, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
